// File: rtl/incr_rr_sched.sv
// Round-robin scheduler sharing one registered incrementer.
// Grants one requester per cycle and returns operand+STEP tagged with its id.
module incr_rr_sched #(
  parameter int NREQ = 4,
  parameter int WIDTH = 70,
  parameter logic [WIDTH-1:0] STEP = WIDTH'(1),
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  enable,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_carry,
  output logic                  busy
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDW-1:0]   last_grant;
  logic             can_accept;
  logic             accept;
  logic             found;
  logic [IDW-1:0]   gnt_id;
  logic [WIDTH-1:0] gnt_data;
  logic [IDW:0]     probe;
  logic [IDW-1:0]   idx;
  logic [WIDTH-1:0] ops [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_ops
    assign ops[i] = req_data[i*WIDTH +: WIDTH];
  end

  assign can_accept = enable & reset_l &
                      ((state_q == IDLE) | rsp_ready);

  // Rotating search starting just past the last winner.
  always_comb begin
    req_ready = '0;
    found     = 1'b0;
    gnt_id    = '0;
    gnt_data  = '0;
    probe     = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      probe = {1'b0, last_grant} + (IDW+1)'(k);
      if (probe >= (IDW+1)'(NREQ))
        probe = probe - (IDW+1)'(NREQ);
      idx = probe[IDW-1:0];
      if (can_accept && !found && req_valid[idx]) begin
        found          = 1'b1;
        gnt_id         = idx;
        gnt_data       = ops[idx];
        req_ready[idx] = 1'b1;
      end
    end
  end

  assign accept = |(req_valid & req_ready);

  // Next state: a response is held until consumed or replaced.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = HOLD;
      HOLD: if (rsp_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Result and priority pointer capture on each accept.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      last_grant <= IDW'(NREQ-1);
    end else if (accept) begin
      rsp_id     <= gnt_id;
      {rsp_carry, rsp_data} <= {1'b0, gnt_data} + {1'b0, STEP};
      last_grant <= gnt_id;
    end
  end

  assign rsp_valid = (state_q == HOLD);
  assign busy      = rsp_valid;

endmodule

// File: tb/tb_incr_rr_sched.sv
// Bench for incr_rr_sched: directed steps plus random traffic
// checked against a behavioural scheduler model.
module tb_incr_rr_sched;

  localparam int NREQ = 4;
  localparam int WIDTH = 70;
  localparam int IDW = 2;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

  logic                  clk = 1'b0;
  logic                  reset_l;
  logic                  enable;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_carry;
  logic                  busy;

  int vectors = 0;
  int miscompares = 0;

  int               m_lg;
  bit               m_valid;
  int               m_id;
  logic [WIDTH-1:0] m_data;
  bit               m_carry;

  logic [NREQ-1:0]  rdy;
  logic [WIDTH-1:0] ones;

  incr_rr_sched #(
    .NREQ(NREQ),
    .WIDTH(WIDTH),
    .STEP(STEP)
  ) dut (
    .clk(clk),
    .reset_l(reset_l),
    .enable(enable),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_carry(rsp_carry),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [WIDTH:0] obs,
                     input logic [WIDTH:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] get_op(input int i);
    logic [NREQ*WIDTH-1:0] t;
    t = req_data >> (i * WIDTH);
    return t[WIDTH-1:0];
  endfunction

  task automatic set_op(input int i, input logic [WIDTH-1:0] v);
    req_data[i*WIDTH +: WIDTH] = v;
  endtask

  // Who the spec says wins this cycle, or -1 for nobody.
  function automatic int exp_grant();
    int i;
    if (!reset_l || !enable) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      i = (m_lg + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_lg    = NREQ - 1;
    m_valid = 0;
    m_id    = 0;
    m_data  = '0;
    m_carry = 0;
  endtask

  // Check outputs against the model, then advance one clock.
  task automatic cycle(output logic [NREQ-1:0] seen);
    int g;
    logic [NREQ-1:0] er;
    logic [WIDTH:0]  sum;
    #1;
    g  = exp_grant();
    er = (g >= 0) ? NREQ'(1) << g : '0;
    seen = req_ready;
    chk("req_ready", {67'd0, req_ready}, {67'd0, er});
    chk("rsp_valid", {70'd0, rsp_valid}, {70'd0, m_valid});
    chk("busy", {70'd0, busy}, {70'd0, m_valid});
    chk("rsp_id", {69'd0, rsp_id}, (WIDTH+1)'(m_id));
    chk("rsp_data", {1'b0, rsp_data}, {1'b0, m_data});
    chk("rsp_carry", {70'd0, rsp_carry}, {70'd0, m_carry});
    if (!reset_l) begin
      model_reset();
    end else if (g >= 0) begin
      sum = {1'b0, get_op(g)} + {1'b0, STEP};
      m_carry = sum[WIDTH];
      m_data  = sum[WIDTH-1:0];
      m_valid = 1;
      m_id    = g;
      m_lg    = g;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    ones      = '1;
    reset_l   = 1'b0;
    enable    = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    cycle(rdy);
    chk("reset_ready", {67'd0, rdy}, '0);

    // All requesters valid: strict 0,1,2,3 rotation.
    reset_l = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++)
      set_op(i, WIDTH'(i * 16 + 5));
    for (int k = 0; k < 8; k++) begin
      cycle(rdy);
      chk("t1_rr", {67'd0, rdy}, (WIDTH+1)'(1 << (k % 4)));
    end

    // Wide operand zero-extended from 40 bits.
    req_valid = 4'b0010;
    set_op(1, WIDTH'(40'hFF_FFFF_FFFF));
    cycle(rdy);
    req_valid = '0;
    #1;
    chk("t2_data", {1'b0, rsp_data}, 71'h100_0000_0000);
    chk("t2_id", {69'd0, rsp_id}, 71'd1);
    chk("t2_carry", {70'd0, rsp_carry}, 71'd0);
    cycle(rdy);

    // All-ones wraps to zero with carry.
    req_valid = 4'b0100;
    set_op(2, ones);
    cycle(rdy);
    req_valid = '0;
    #1;
    chk("t3_data", {1'b0, rsp_data}, 71'd0);
    chk("t3_carry", {70'd0, rsp_carry}, 71'd1);
    cycle(rdy);

    // Backpressure: nothing granted, response stable.
    req_valid = '1;
    cycle(rdy);
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(rdy);
      chk("t4_stall", {67'd0, rdy}, '0);
    end
    rsp_ready = 1'b1;
    cycle(rdy);

    // Disabled while holding: drains, then no grants.
    rsp_ready = 1'b0;
    enable = 1'b0;
    cycle(rdy);
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) cycle(rdy);
    chk("t5_drained", {70'd0, rsp_valid}, 71'd0);
    enable = 1'b1;
    cycle(rdy);

    // Reset while holding: response dropped, req 0 first.
    cycle(rdy);
    reset_l = 1'b0;
    cycle(rdy);
    reset_l = 1'b1;
    #1;
    chk("t6_valid", {70'd0, rsp_valid}, 71'd0);
    chk("t6_first", {67'd0, req_ready}, 71'd1);
    cycle(rdy);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      reset_l   = ($urandom_range(0, 59) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 3))
          0: set_op(i, ones);
          1: set_op(i, ones - WIDTH'($urandom_range(0, 3)));
          default:
            set_op(i, {$urandom, $urandom, $urandom});
        endcase
      end
      cycle(rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
